// File: rtl/fp_pkg.sv
// Shared FPU types: rounding modes, operand classes, exception flags, and
// width-parametric builders for the canonical NaN and max-finite encodings.
package fp_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rmode_e;

    typedef enum logic [2:0] {
        CL_ZERO,
        CL_NORM,
        CL_INF,
        CL_QNAN,
        CL_SNAN
    } fclass_e;

    typedef struct packed {
        logic nv;
        logic ovrf;
        logic udrf;
        logic nx;
    } fp_flags_t;

    localparam int CONST_W = 128;

    // Callers truncate the result to 1+exp_w+man_w bits; sign bit is always 0.
    function automatic logic [CONST_W-1:0] canon_nan(input int exp_w, input int man_w);
        return (((CONST_W'(1) << exp_w) - CONST_W'(1)) << man_w) | (CONST_W'(1) << (man_w - 1));
    endfunction

    function automatic logic [CONST_W-1:0] max_finite(input int exp_w, input int man_w);
        return (((CONST_W'(1) << exp_w) - CONST_W'(2)) << man_w) | ((CONST_W'(1) << man_w) - CONST_W'(1));
    endfunction

endpackage

// File: rtl/fp_round.sv
// Rounding decision and mantissa increment; a carry-out means the rounded
// mantissa wrapped to zero and the caller must bump the exponent.
module fp_round
    import fp_pkg::*;
#(
    parameter int MAN_W = 23
) (
    input  logic             sign,
    input  logic [MAN_W-1:0] man,
    input  logic             g,
    input  logic             s,
    input  logic [2:0]       r_mode,
    output logic [MAN_W-1:0] man_rounded,
    output logic             carry
);

    logic up;

    always_comb begin
        case (r_mode)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign & (g | s);
            RM_RUP:  up = ~sign & (g | s);
            RM_RMM:  up = g;
            default: up = g & (s | man[0]);
        endcase
        {carry, man_rounded} = {1'b0, man} + (MAN_W+1)'(up);
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier: classify/multiply, normalise,
// round/pack. One advance signal stalls every stage together when the output is blocked.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] fp_X,
    input  logic [EXP_W+MAN_W:0] fp_Y,
    input  logic [2:0]           r_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] fp_Z,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 ovrf,
    output logic                 udrf,
    output logic                 nx,
    output logic                 nv
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;

    localparam logic [W-1:0]         QNAN_Z   = W'(canon_nan(EXP_W, MAN_W));
    localparam logic [W-1:0]         MAXF_Z   = W'(max_finite(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [EW-1:0]        BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_OVF  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [EW-1:0]    exp;
        logic [PW-1:0]    prod;
        logic [2:0]       rmode;
        logic [TAG_W-1:0] tag;
        logic             spec;
        logic             nv;
        logic [W-1:0]     spec_z;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [EW-1:0]    exp;
        logic [MAN_W-1:0] man;
        logic             g;
        logic             s;
        logic [2:0]       rmode;
        logic [TAG_W-1:0] tag;
        logic             spec;
        logic             nv;
        logic [W-1:0]     spec_z;
    } s2_t;

    typedef struct packed {
        logic             valid;
        logic [W-1:0]     z;
        logic [TAG_W-1:0] tag;
        fp_flags_t        flags;
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    logic                 advance;
    fclass_e              cls_x, cls_y;
    logic                 sign_xy;
    logic [PW-2:0]        norm;
    logic [MAN_W-1:0]     man_r;
    logic                 rnd_carry;
    logic signed [EW-1:0] e_fin;

    // Subnormals classify as zero (DAZ).
    function automatic fclass_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) return CL_ZERO;
        if (e != EXP_ONES) return CL_NORM;
        if (m == '0) return CL_INF;
        return m[MAN_W-1] ? CL_QNAN : CL_SNAN;
    endfunction

    assign advance  = !s3_q.valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        cls_x   = classify(fp_X[W-2 -: EXP_W], fp_X[MAN_W-1:0]);
        cls_y   = classify(fp_Y[W-2 -: EXP_W], fp_Y[MAN_W-1:0]);
        sign_xy = fp_X[W-1] ^ fp_Y[W-1];
        s1_d    = s1_q;
        if (advance) begin
            s1_d.valid  = in_valid;
            s1_d.sign   = sign_xy;
            s1_d.exp    = EW'(fp_X[W-2 -: EXP_W]) + EW'(fp_Y[W-2 -: EXP_W]) - BIAS;
            s1_d.prod   = PW'({1'b1, fp_X[MAN_W-1:0]}) * PW'({1'b1, fp_Y[MAN_W-1:0]});
            s1_d.rmode  = r_mode;
            s1_d.tag    = in_tag;
            s1_d.spec   = 1'b1;
            s1_d.nv     = 1'b0;
            s1_d.spec_z = QNAN_Z;
            if (cls_x == CL_SNAN || cls_y == CL_SNAN ||
                (cls_x == CL_ZERO && cls_y == CL_INF) ||
                (cls_x == CL_INF && cls_y == CL_ZERO)) begin
                s1_d.nv = 1'b1;
            end else if (cls_x == CL_QNAN || cls_y == CL_QNAN) begin
                s1_d.nv = 1'b0;
            end else if (cls_x == CL_INF || cls_y == CL_INF) begin
                s1_d.spec_z = {sign_xy, EXP_ONES, {MAN_W{1'b0}}};
            end else if (cls_x == CL_ZERO || cls_y == CL_ZERO) begin
                s1_d.spec_z = {sign_xy, {(W-1){1'b0}}};
            end else begin
                s1_d.spec = 1'b0;
            end
        end
    end

    // norm drops the hidden bit: the top MAN_W bits are the mantissa, then G, then sticky.
    always_comb begin
        norm = s1_q.prod[PW-1] ? s1_q.prod[PW-2:0] : {s1_q.prod[PW-3:0], 1'b0};
        s2_d = s2_q;
        if (advance) begin
            s2_d.valid  = s1_q.valid;
            s2_d.sign   = s1_q.sign;
            s2_d.exp    = s1_q.exp + EW'(s1_q.prod[PW-1]);
            s2_d.man    = norm[PW-2 -: MAN_W];
            s2_d.g      = norm[MAN_W];
            s2_d.s      = |norm[MAN_W-1:0];
            s2_d.rmode  = s1_q.rmode;
            s2_d.tag    = s1_q.tag;
            s2_d.spec   = s1_q.spec;
            s2_d.nv     = s1_q.nv;
            s2_d.spec_z = s1_q.spec_z;
        end
    end

    fp_round #(.MAN_W(MAN_W)) u_round (
        .sign        (s2_q.sign),
        .man         (s2_q.man),
        .g           (s2_q.g),
        .s           (s2_q.s),
        .r_mode      (s2_q.rmode),
        .man_rounded (man_r),
        .carry       (rnd_carry)
    );

    always_comb begin
        e_fin = s2_q.exp + EW'(rnd_carry);
        s3_d  = s3_q;
        if (advance) begin
            s3_d = '0;
            if (s2_q.valid) begin
                s3_d.valid = 1'b1;
                s3_d.tag   = s2_q.tag;
                if (s2_q.spec) begin
                    s3_d.z        = s2_q.spec_z;
                    s3_d.flags.nv = s2_q.nv;
                end else if (e_fin >= EXP_OVF) begin
                    s3_d.flags.ovrf = 1'b1;
                    s3_d.flags.nx   = 1'b1;
                    case (s2_q.rmode)
                        RM_RTZ:  s3_d.z = {s2_q.sign, MAXF_Z[W-2:0]};
                        RM_RDN:  s3_d.z = s2_q.sign ? {1'b1, EXP_ONES, {MAN_W{1'b0}}} : MAXF_Z;
                        RM_RUP:  s3_d.z = s2_q.sign ? {1'b1, MAXF_Z[W-2:0]} : {1'b0, EXP_ONES, {MAN_W{1'b0}}};
                        default: s3_d.z = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
                    endcase
                end else if (e_fin <= EXP_ZERO) begin
                    s3_d.z          = {s2_q.sign, {(W-1){1'b0}}};
                    s3_d.flags.udrf = 1'b1;
                    s3_d.flags.nx   = 1'b1;
                end else begin
                    s3_d.z        = {s2_q.sign, e_fin[EXP_W-1:0], man_r};
                    s3_d.flags.nx = s2_q.g | s2_q.s;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign out_valid = s3_q.valid;
    assign fp_Z      = s3_q.z;
    assign out_tag   = s3_q.tag;
    assign ovrf      = s3_q.flags.ovrf;
    assign udrf      = s3_q.flags.udrf;
    assign nx        = s3_q.flags.nx;
    assign nv        = s3_q.flags.nv;

endmodule
